psi_index_serializer: RTL and testbench

Downstream stage of the PSI intersection block. It accepts the b-bit intersection bitmap (bit k set means element k is in every party's set) and streams out the indices of the set bits, lowest first, one per cycle over a valid/ready handshake. It reports the cardinality of the intersection and pulses a completion flag. This turns the bitmap result into an element list for output formatting or a later protocol stage.

---
 rtl/psi_index_serializer_if.sv | 26 ++
 rtl/psi_index_serializer.sv | 117 +++++++++++
 tb/tb_psi_index_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/psi_index_serializer_if.sv
// Handshake bundle between the PSI bitmap producer, the index serializer and
// the index consumer. The serializer uses the slave view.
interface psi_index_serializer_if #(
  parameter int b = 10,
  parameter int w = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [b-1:0] in_set;
  logic         out_valid;
  logic         out_ready;
  logic [w-1:0] out_idx;
  logic         out_last;
  logic [w:0]   count;
  logic         done;

  modport slave (
    input  in_valid, in_set, out_ready,
    output in_ready, out_valid, out_idx, out_last, count, done
  );

  modport master (
    output in_valid, in_set, out_ready,
    input  in_ready, out_valid, out_idx, out_last, count, done
  );
endinterface

// File: rtl/psi_index_serializer.sv
// Streams the indices of the set bits of a PSI intersection bitmap, lowest
// first, one per accepted beat, and reports the cardinality plus a done pulse.
module psi_index_serializer #(
  parameter int b = 10,
  parameter int w = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  psi_index_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_r;
  logic [b-1:0] mask_r;
  logic [w:0]   count_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [w-1:0] out_idx_r;
  logic         out_last_r;
  logic         done_r;

  function automatic logic [w-1:0] lowest_idx(input logic [b-1:0] m);
    logic [w-1:0] idx;
    idx = {w{1'b0}};
    for (int i = b - 1; i >= 0; i--) begin
      if (m[i]) idx = w'(i);
    end
    return idx;
  endfunction

  function automatic logic [b-1:0] clear_lowest(input logic [b-1:0] m);
    return m & (m - {{(b-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic single_bit(input logic [b-1:0] m);
    return (m != {b{1'b0}}) && (clear_lowest(m) == {b{1'b0}});
  endfunction

  // Index and last flag are precomputed from the next mask so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mask_r      <= {b{1'b0}};
      count_r     <= {(w+1){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_idx_r   <= {w{1'b0}};
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            mask_r     <= bus.in_set;
            count_r    <= {(w+1){1'b0}};
            in_ready_r <= 1'b0;
            if (bus.in_set != {b{1'b0}}) begin
              state_r     <= ST_SCAN;
              out_valid_r <= 1'b1;
              out_idx_r   <= lowest_idx(bus.in_set);
              out_last_r  <= single_bit(bus.in_set);
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (bus.out_ready) begin
            mask_r  <= clear_lowest(mask_r);
            count_r <= count_r + {{w{1'b0}}, 1'b1};
            if (out_last_r) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b0;
              out_idx_r   <= {w{1'b0}};
              out_last_r  <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              out_idx_r  <= lowest_idx(clear_lowest(mask_r));
              out_last_r <= single_bit(clear_lowest(mask_r));
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          mask_r      <= {b{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_idx_r   <= {w{1'b0}};
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;
  assign bus.count     = count_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_psi_index_serializer.sv
// Directed bench for psi_index_serializer: each step drives inputs just after
// a rising edge and checks outputs against hand-computed values.
module tb_psi_index_serializer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  psi_index_serializer_if #(.b(10), .w(4)) bus ();

  psi_index_serializer #(.b(10), .w(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One output beat: check it is presented, then clock it.
  task automatic beat(input string tag, input int idx, input bit last);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " idx"},   32'(bus.out_idx),   32'(idx));
    chk({tag, " last"},  32'(bus.out_last),  32'(last));
    step();
  endtask

  task automatic check_done(input string tag, input int cnt);
    chk({tag, " done"},      32'(bus.done),      32'd1);
    chk({tag, " count"},     32'(bus.count),     32'(cnt));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'd0);
    step();
    chk({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " idle done"},     32'(bus.done),     32'd0);
    chk({tag, " idle count"},    32'(bus.count),    32'(cnt));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_set    = 10'd0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset count",     32'(bus.count),     32'd0);
    chk("reset done",      32'(bus.done),      32'd0);
    chk("reset idx",       32'(bus.out_idx),   32'd0);
    chk("reset last",      32'(bus.out_last),  32'd0);

    // Sparse set
    bus.in_valid = 1'b1; bus.in_set = 10'b1000100101; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    beat("sparse 0", 0, 1'b0);
    beat("sparse 2", 2, 1'b0);
    beat("sparse 5", 5, 1'b0);
    beat("sparse 9", 9, 1'b1);
    check_done("sparse", 4);

    // Empty set
    bus.in_valid = 1'b1; bus.in_set = 10'd0;
    step();
    bus.in_valid = 1'b0;
    check_done("empty", 0);
    chk("empty no valid", 32'(bus.out_valid), 32'd0);

    // Full set with alternating backpressure
    bus.in_valid = 1'b1; bus.in_set = 10'h3FF; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("full stall valid", 32'(bus.out_valid), 32'd1);
      chk("full stall idx",   32'(bus.out_idx),   32'(i));
      chk("full stall count", 32'(bus.count),     32'(i));
      step();
      bus.out_ready = 1'b1;
      beat("full", i, i == 9);
      bus.out_ready = 1'b0;
    end
    check_done("full", 10);

    // Single MSB
    bus.in_valid = 1'b1; bus.in_set = 10'b1000000000; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    beat("msb", 9, 1'b1);
    check_done("msb", 1);

    // Input blocked while scanning
    bus.in_valid = 1'b1; bus.in_set = 10'b0000000110;
    step();
    bus.in_set = 10'h3FF;
    chk("blocked in_ready a", 32'(bus.in_ready), 32'd0);
    beat("blocked 1", 1, 1'b0);
    chk("blocked in_ready b", 32'(bus.in_ready), 32'd0);
    beat("blocked 2", 2, 1'b1);
    chk("blocked done", 32'(bus.done), 32'd1);
    chk("blocked count", 32'(bus.count), 32'd2);
    chk("blocked in_ready c", 32'(bus.in_ready), 32'd0);
    step();
    chk("blocked idle", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("second captured", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 10; i++) beat("second", i, i == 9);
    check_done("second", 10);

    // Reset mid-scan
    bus.in_valid = 1'b1; bus.in_set = 10'b0001111000;
    step();
    bus.in_valid = 1'b0;
    beat("midrst 3", 3, 1'b0);
    beat("midrst 4", 4, 1'b0);
    chk("midrst pre count", 32'(bus.count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst count",     32'(bus.count),     32'd0);
    chk("midrst done",      32'(bus.done),      32'd0);
    chk("midrst in_ready",  32'(bus.in_ready),  32'd1);
    step();
    chk("midrst no done", 32'(bus.done), 32'd0);
    bus.in_valid = 1'b1; bus.in_set = 10'b0000000001;
    step();
    bus.in_valid = 1'b0;
    beat("fresh 0", 0, 1'b1);
    check_done("fresh", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
